// File: rtl/qnet_cmd_tx_mux_pkg.sv
// qnet_cmd_tx_mux_pkg
//   Shared constants, types and helpers for the network command TX mux:
//   sync byte, beat field offsets, FSM state enum, FIFO entry layout,
//   saturating counter increment and beat0 header builder.
package qnet_cmd_tx_mux_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h5A;

  localparam int OP_W     = 5;
  localparam int DT_W     = 32;
  localparam int MASK_MAX = 4;   // widest supported link count
  localparam int BEAT_W   = 64;
  localparam int CNT_W    = 16;

  // beat0 field offsets (LSB position inside the 64-bit word)
  localparam int SYNC_OFS = 56;
  localparam int SEQ_OFS  = 40;
  localparam int EFF_OFS  = 32;
  localparam int OP_OFS   = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_BEAT0 = 3'd2,
    ST_BEAT1 = 3'd3,
    ST_BEAT2 = 3'd4
  } state_e;

  // Mask is stored at the widest size so the entry layout does not depend on NCH.
  typedef struct packed {
    logic [OP_W-1:0]     op;
    logic [MASK_MAX-1:0] mask;
    logic [DT_W-1:0]     dt1;
    logic [DT_W-1:0]     dt2;
    logic [DT_W-1:0]     dt3;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [BEAT_W-1:0] beat0_word(input logic [15:0]     seq,
                                                   input logic [7:0]      eff,
                                                   input logic [OP_W-1:0] op);
    logic [BEAT_W-1:0] w;
    w = '0;
    w[SYNC_OFS +: 8]  = SYNC_BYTE;
    w[SEQ_OFS  +: 16] = seq;
    w[EFF_OFS  +: 8]  = eff;
    w[OP_OFS   +: 8]  = {3'b000, op};
    return w;
  endfunction

endpackage

// File: rtl/qnet_cmd_tx_mux_if.sv
// qnet_cmd_if / qnet_axis_if
//   qnet_cmd_if : tProc command port. master = command source, slave = mux.
//     cmd, op[4:0], ch_mask[NCH-1:0], dt1/dt2/dt3[31:0] toward the mux; ready back.
//   qnet_axis_if: per-link AXI-Stream TX bus. master = mux, slave = Aurora side.
//     tdata[NCH*64-1:0] (link k at [64k+63:64k]), tvalid, tlast toward links; tready back.
interface qnet_cmd_if #(parameter int NCH = 2);
  import qnet_cmd_tx_mux_pkg::*;

  logic                cmd;
  logic [OP_W-1:0]     op;
  logic [NCH-1:0]      ch_mask;
  logic [DT_W-1:0]     dt1;
  logic [DT_W-1:0]     dt2;
  logic [DT_W-1:0]     dt3;
  logic                ready;

  modport master (output cmd, op, ch_mask, dt1, dt2, dt3, input ready);
  modport slave  (input cmd, op, ch_mask, dt1, dt2, dt3, output ready);
endinterface

interface qnet_axis_if #(parameter int NCH = 2);
  import qnet_cmd_tx_mux_pkg::*;

  logic [NCH*BEAT_W-1:0] tdata;
  logic [NCH-1:0]        tvalid;
  logic [NCH-1:0]        tlast;
  logic [NCH-1:0]        tready;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/qnet_cmd_tx_mux_sfifo.sv
// qnet_sfifo
//   Single-clock FIFO, DEPTH = 2**AW. Data written in cycle N is visible on
//   rd_data_o in cycle N+1. A write into a full FIFO is accepted when a read
//   happens in the same cycle (count unchanged).
//   clk_i, rst_ni      clock, async active-low reset
//   wr_en_i/wr_data_i  write port
//   rd_en_i/rd_data_o  read port (show-ahead: rd_data_o is the head entry)
//   full_o, empty_o, count_o  occupancy
module qnet_sfifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             wr_ok, rd_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  assign rd_ok = rd_en_i & ~empty_o;
  assign wr_ok = wr_en_i & (~full_o | rd_ok);

  assign rd_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/qnet_cmd_tx_mux.sv
// qnet_cmd_tx_mux
//   Buffers tProc network commands, frames each as a 2- or 3-beat 64-bit
//   AXI-Stream packet and sends it on one or several of NCH links with
//   per-link backpressure and channel_up gating.
//   c_clk_i, c_rst_ni   core clock, async active-low reset
//   cmd_if (slave)      command strobe/op/mask/payload in, ready out
//   channel_up_i        per-link Aurora channel_up
//   m_axis (master)     per-link tdata/tvalid/tlast out, tready in
//   busy_o              FSM active or FIFO holding entries
//   seq_o               sequence number of the next packet
//   drop/skip/abort_cnt_o  saturating event counters
//
//   state  | meaning
//   IDLE   | nothing in flight, waiting for a FIFO entry
//   LOAD   | pop entry, compute effective link mask
//   BEAT0  | header beat (sync, seq, eff, op)
//   BEAT1  | payload {dt1, dt2}; last beat when op[4]=0
//   BEAT2  | payload {dt3, 0}; last beat of a 3-beat packet
module qnet_cmd_tx_mux
  import qnet_cmd_tx_mux_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int FIFO_AW = 3
) (
  input  logic             c_clk_i,
  input  logic             c_rst_ni,
  qnet_cmd_if.slave        cmd_if,
  input  logic [NCH-1:0]   channel_up_i,
  qnet_axis_if.master      m_axis,
  output logic             busy_o,
  output logic [CNT_W-1:0] seq_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic [CNT_W-1:0] skip_cnt_o,
  output logic [CNT_W-1:0] abort_cnt_o
);

  state_e              state_q, state_d;
  logic [NCH-1:0]      pend_q, pend_d;
  logic [NCH-1:0]      eff_q, eff_d;
  logic [7:0]          hdr_eff_q, hdr_eff_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DT_W-1:0]     dt1_q, dt1_d, dt2_q, dt2_d, dt3_q, dt3_d;
  logic [CNT_W-1:0]    seq_q, seq_d;
  logic [CNT_W-1:0]    drop_q, drop_d, skip_q, skip_d, abort_q, abort_d;

  entry_t              wr_entry, rd_entry;
  logic                fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [FIFO_AW:0]    fifo_count;

  logic                in_beat, last_beat, more;
  logic [NCH-1:0]      hs, lost, eff_rem, pend_rem;
  logic [MASK_MAX-1:0] eff_wide;
  logic [BEAT_W-1:0]   beat_data;

  assign wr_entry = '{op: cmd_if.op, mask: MASK_MAX'(cmd_if.ch_mask),
                      dt1: cmd_if.dt1, dt2: cmd_if.dt2, dt3: cmd_if.dt3};

  assign fifo_wr      = cmd_if.cmd & ~fifo_full;
  assign fifo_rd      = (state_q == ST_LOAD);
  assign cmd_if.ready = ~fifo_full;

  qnet_sfifo #(.WIDTH(ENTRY_W), .AW(FIFO_AW)) u_fifo (
    .clk_i     (c_clk_i),
    .rst_ni    (c_rst_ni),
    .wr_en_i   (fifo_wr),
    .wr_data_i (wr_entry),
    .rd_en_i   (fifo_rd),
    .rd_data_o (rd_entry),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign in_beat   = (state_q == ST_BEAT0) || (state_q == ST_BEAT1) || (state_q == ST_BEAT2);
  assign last_beat = (state_q == ST_BEAT2) || ((state_q == ST_BEAT1) && !op_q[4]);
  // A write this cycle lets the next packet start without an extra IDLE cycle.
  assign more      = ~fifo_empty | fifo_wr;
  assign hs        = m_axis.tvalid & m_axis.tready;
  assign lost      = in_beat ? (eff_q & ~channel_up_i) : '0;
  assign eff_rem   = eff_q & ~lost;
  assign pend_rem  = pend_q & ~hs & ~lost;
  assign eff_wide  = rd_entry.mask & MASK_MAX'(channel_up_i);

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    eff_d     = eff_q;
    hdr_eff_d = hdr_eff_q;
    op_d      = op_q;
    dt1_d     = dt1_q;
    dt2_d     = dt2_q;
    dt3_d     = dt3_q;
    seq_d     = seq_q;
    skip_d    = skip_q;
    abort_d   = (|lost) ? sat_inc(abort_q) : abort_q;
    drop_d    = (cmd_if.cmd & fifo_full) ? sat_inc(drop_q) : drop_q;

    case (state_q)
      ST_IDLE: begin
        if (more) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        op_d  = rd_entry.op;
        dt1_d = rd_entry.dt1;
        dt2_d = rd_entry.dt2;
        dt3_d = rd_entry.dt3;
        if (eff_wide == '0) begin
          skip_d  = sat_inc(skip_q);
          state_d = ST_IDLE;
        end else begin
          eff_d     = eff_wide[NCH-1:0];
          pend_d    = eff_wide[NCH-1:0];
          hdr_eff_d = 8'(eff_wide[NCH-1:0]);
          state_d   = ST_BEAT0;
        end
      end
      ST_BEAT0, ST_BEAT1, ST_BEAT2: begin
        eff_d  = eff_rem;
        pend_d = pend_rem;
        if (eff_rem == '0) begin
          // every target link went down: abandon the packet, seq unchanged
          pend_d  = '0;
          state_d = ST_IDLE;
        end else if (pend_rem == '0) begin
          pend_d = eff_rem;
          if (last_beat) begin
            seq_d   = seq_q + 1'b1;
            state_d = more ? ST_LOAD : ST_IDLE;
          end else if (state_q == ST_BEAT0) begin
            state_d = ST_BEAT1;
          end else begin
            state_d = ST_BEAT2;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
    if (!c_rst_ni) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      eff_q     <= '0;
      hdr_eff_q <= '0;
      op_q      <= '0;
      dt1_q     <= '0;
      dt2_q     <= '0;
      dt3_q     <= '0;
      seq_q     <= '0;
      drop_q    <= '0;
      skip_q    <= '0;
      abort_q   <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      eff_q     <= eff_d;
      hdr_eff_q <= hdr_eff_d;
      op_q      <= op_d;
      dt1_q     <= dt1_d;
      dt2_q     <= dt2_d;
      dt3_q     <= dt3_d;
      seq_q     <= seq_d;
      drop_q    <= drop_d;
      skip_q    <= skip_d;
      abort_q   <= abort_d;
    end
  end

  // Header uses the mask latched at LOAD so tdata stays stable if a link drops mid-beat.
  always_comb begin
    case (state_q)
      ST_BEAT0: beat_data = beat0_word(seq_q, hdr_eff_q, op_q);
      ST_BEAT1: beat_data = {dt1_q, dt2_q};
      ST_BEAT2: beat_data = {dt3_q, 32'h0};
      default:  beat_data = '0;
    endcase
  end

  assign m_axis.tdata  = {NCH{beat_data}};
  assign m_axis.tvalid = in_beat ? pend_q : '0;
  assign m_axis.tlast  = last_beat ? pend_q : '0;

  assign busy_o      = (state_q != ST_IDLE) || (fifo_count != '0);
  assign seq_o       = seq_q;
  assign drop_cnt_o  = drop_q;
  assign skip_cnt_o  = skip_q;
  assign abort_cnt_o = abort_q;

endmodule
